// File: rtl/iana_tx_buffer_if.sv
// Trace-side and DMA-side handshake bundle for iana_tx_buffer.
// The buffer connects through the slave modport; the CPU/DMA environment uses master.
interface iana_tx_buffer_if;
  logic [127:0] trace_in;
  logic         trace_valid;
  logic         trace_ready;
  logic [127:0] dma_in;
  logic         dma_we;
  logic         dma_writable;

  modport master (output trace_in, trace_valid, dma_writable,
                  input  trace_ready, dma_in, dma_we);
  modport slave  (input  trace_in, trace_valid, dma_writable,
                  output trace_ready, dma_in, dma_we);
endinterface

// File: rtl/iana_tx_buffer.sv
// Trace-to-DMA transmit FIFO with almost-full stall, overflow accounting and flush drain.
// Define IANA_TX_MARKER_EN to append an end-of-capture marker record after a flush.
module iana_tx_buffer #(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                   clock2,
  input  logic                   nreset,
  input  logic                   enable,
  input  logic                   flush,
  iana_tx_buffer_if.slave        bus,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

`ifdef IANA_TX_MARKER_EN
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, MARK} state_t;
  localparam logic [127:0] MARKER = 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000;
`else
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
`endif

  state_t        state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, level_next;
  logic [127:0]  dma_in_q, dma_in_d;
  logic          dma_we_q, dma_we_d;
  logic          stall_req_q, stall_req_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          flush_q, flush_d;
  logic [127:0]  mem_q [DEPTH];

  logic empty, full, pop, push_ok, push, drop, pop_state, flush_rise;

  assign level = wptr_q - rptr_q;
  assign empty = (level == '0);
  assign full  = (level == PW'(DEPTH));
  assign flush_rise = flush & ~flush_q;

`ifdef IANA_TX_MARKER_EN
  assign pop_state = (state_q != MARK);
`else
  assign pop_state = 1'b1;
`endif

  // A pop frees a slot this cycle, so a push is legal at full when one happens.
  assign pop     = pop_state & ~empty & bus.dma_writable;
  assign push_ok = enable & (state_q != FLUSH) & (~full | pop);
  assign push    = push_ok & bus.trace_valid;
  assign drop    = bus.trace_valid & enable & (state_q != FLUSH) & full & ~pop;

  assign bus.trace_ready = push_ok;
  assign bus.dma_in      = dma_in_q;
  assign bus.dma_we      = dma_we_q;
  assign stall_req       = stall_req_q;
  assign overflow        = overflow_q;
  assign drop_count      = drop_count_q;
  assign busy            = (state_q != IDLE) | ~empty;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q + PW'(push);
    rptr_d       = rptr_q + PW'(pop);
    level_next   = wptr_d - rptr_d;
    stall_req_d  = (level_next >= PW'(DEPTH - AFULL_MARGIN));
    dma_in_d     = dma_in_q;
    dma_we_d     = 1'b0;
    overflow_d   = overflow_q | drop;
    drop_count_d = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
    flush_d      = flush;
    if (pop) begin
      dma_in_d = mem_q[rptr_q[AW-1:0]];
      dma_we_d = 1'b1;
    end
    case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN: begin
        if (flush_rise)            state_d = FLUSH;
        else if (!enable && empty) state_d = IDLE;
      end
`ifdef IANA_TX_MARKER_EN
      FLUSH: if (empty) state_d = MARK;
      MARK: begin
        if (bus.dma_writable) begin
          dma_in_d = MARKER | {112'd0, drop_count_q};
          dma_we_d = 1'b1;
          state_d  = IDLE;
        end
      end
`else
      FLUSH: if (empty) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock2 or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      dma_in_q     <= '0;
      dma_we_q     <= 1'b0;
      stall_req_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      dma_in_q     <= dma_in_d;
      dma_we_q     <= dma_we_d;
      stall_req_q  <= stall_req_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      flush_q      <= flush_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock2) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= bus.trace_in;
  end
endmodule
